// File: rtl/vector_exec_sequencer_pkg.sv
// Shared definitions for the vector execution sequencer.
//   - opcode width and opcode class encodings (opcode bits [4:3])
//   - sequencer state enumeration
//   - helper to extract the class field from an opcode
`timescale 1ns/1ps
package vector_exec_sequencer_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [1:0] CLASS_INT   = 2'b00;
  localparam logic [1:0] CLASS_FIXED = 2'b01;
  localparam logic [1:0] CLASS_VEC   = 2'b10;
  localparam logic [1:0] CLASS_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Class field lives in the two most significant opcode bits.
  function automatic logic [1:0] op_class(input logic [OPCODE_W-1:0] op);
    return op[OPCODE_W-1 -: 2];
  endfunction

endpackage

// File: rtl/vector_exec_sequencer.sv
// Vector execution sequencer.
// Accepts one instruction (opcode + two packed lane operands), then steps a
// shared external combinational ALU across the lanes one per cycle and
// presents the packed result with a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake
//   in_opcode                5-bit opcode, bits [4:3] = class
//   in_a, in_b               packed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   alu_a, alu_b, alu_opcode operands/opcode driven to the external ALU (0 outside RUN)
//   alu_result               combinational ALU result
//   out_valid/out_ready      result handshake
//   out_result               packed result, same lane layout as in_a
//   out_err                  reserved opcode class flag, qualified by out_valid
//   busy                     high while in RUN or DONE
`timescale 1ns/1ps
module vector_exec_sequencer
  import vector_exec_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [OPCODE_W-1:0]             in_opcode,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_a,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0]           alu_a,
  output logic [DATA_WIDTH-1:0]           alu_b,
  output logic [OPCODE_W-1:0]             alu_opcode,
  input  logic [DATA_WIDTH-1:0]           alu_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_result,
  output logic                            out_err,
  output logic                            busy
);

  localparam int CW = $clog2(NUM_LANES);
  localparam int VW = NUM_LANES * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_VEC = CW'(NUM_LANES - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [VW-1:0]       a_q, a_d;
  logic [VW-1:0]       b_q, b_d;
  logic [VW-1:0]       result_q, result_d;
  logic                err_q, err_d;

  logic [DATA_WIDTH-1:0] lane_a, lane_b;
  logic [CW-1:0]         last_lane;

  // Operand lane selected by the counter; a compare-per-lane mux avoids a
  // variable-width index multiply.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cnt_q == CW'(i)) begin
        lane_a = a_q[i*DATA_WIDTH +: DATA_WIDTH];
        lane_b = b_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Scalar classes only ever touch lane 0.
  assign last_lane = (op_class(op_q) == CLASS_VEC) ? LAST_VEC : '0;

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    err_d      = err_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d     = in_opcode;
          a_d      = in_a;
          b_d      = in_b;
          result_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        alu_a      = lane_a;
        alu_b      = lane_b;
        alu_opcode = op_q;
        if (op_class(op_q) == CLASS_RSVD) begin
          // Reserved class: flag it and finish without capturing the ALU.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          for (int i = 0; i < NUM_LANES; i++) begin
            if (cnt_q == CW'(i)) result_d[i*DATA_WIDTH +: DATA_WIDTH] = alu_result;
          end
          if (cnt_q == last_lane) state_d = S_DONE;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Latched operands are cleared too, so an aborted instruction leaves
      // nothing behind.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Directed testbench for vector_exec_sequencer (DATA_WIDTH 16, NUM_LANES 4)
// with a small external ALU model: opcode[2:0] 0 add, 1 sub, 2 xor, else and.
`timescale 1ns/1ps
module tb_vector_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [63:0] in_a, in_b;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  vector_exec_sequencer #(.DATA_WIDTH(16), .NUM_LANES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode[2:0])
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic offer(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_err", out_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_opcode, 0);
    rst = 1'b0;
    step();

    // Vector ADD, {1,2,3,4} + {10,20,30,40}
    offer(5'b10000, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A);
    step();
    in_valid = 1'b0;
    check("vadd_busy", busy, 1);
    check("vadd_in_ready", in_ready, 0);
    check("vadd_alu_a0", alu_a, 16'd1);
    check("vadd_alu_b0", alu_b, 16'd10);
    check("vadd_alu_op", alu_opcode, 5'b10000);
    step();
    check("vadd_alu_a1", alu_a, 16'd2);
    step(); step();
    check("vadd_alu_b3", alu_b, 16'd40);
    check("vadd_not_yet", out_valid, 0);
    step();
    check("vadd_valid", out_valid, 1);
    check("vadd_result", out_result, 64'h002C_0021_0016_000B);
    check("vadd_err", out_err, 0);
    check("vadd_done_alu_a", alu_a, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("vadd_idle_valid", out_valid, 0);
    check("vadd_idle_ready", in_ready, 1);

    // Integer SUB on lane 0; upper lanes must stay zero
    offer(5'b00001, 64'h0007_0006_0005_0064, 64'h0003_0002_0001_003A);
    step();
    in_valid = 1'b0;
    check("isub_alu_a", alu_a, 16'd100);
    check("isub_alu_b", alu_b, 16'd58);
    step();
    check("isub_valid", out_valid, 1);
    check("isub_result", out_result, 64'h0000_0000_0000_002A);
    check("isub_err", out_err, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reserved class: ALU would produce a nonzero sum, result must stay zero
    offer(5'b11000, 64'h0001_0001_0001_0005, 64'h0001_0001_0001_0007);
    step();
    in_valid = 1'b0;
    step();
    check("rsvd_valid", out_valid, 1);
    check("rsvd_result", out_result, 0);
    check("rsvd_err", out_err, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Vector XOR held in DONE with a second instruction pulsed meanwhile
    offer(5'b10010, 64'h0009_0006_0005_0003, 64'h0001_0001_0001_0001);
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) offer(5'b00000, 64'hFFFF, 64'h1);
      else        in_valid = 1'b0;
      step();
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, 64'h0008_0007_0004_0002);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready, 1);
    step();
    check("hold_no_second", busy, 0);

    // Reset mid-RUN at lane 2, then a clean ADD
    offer(5'b10000, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A);
    step();
    in_valid = 1'b0;
    step(); step();
    check("abort_lane2", alu_a, 16'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_result", out_result, 0);
    check("abort_alu_a", alu_a, 0);
    offer(5'b10000, 64'h0008_0007_0006_0005, 64'h0001_0001_0001_0001);
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_result", out_result, 64'h0009_0008_0007_0006);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset together with in_valid must not accept
    rst = 1'b1;
    offer(5'b10000, 64'h1, 64'h1);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_accept_busy", busy, 0);
    check("rst_accept_ready", in_ready, 1);

    // Back-to-back: second instruction held through the handshake
    out_ready = 1'b1;
    offer(5'b10000, 64'h0004_0003_0002_0001, 64'h0028_001E_0014_000A);
    step();
    offer(5'b10001, 64'h0050_0046_003C_0032, 64'h0004_0003_0002_0001);
    step(); step(); step();
    check("b2b_first_pending", out_valid, 0);
    step();
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_result", out_result, 64'h002C_0021_0016_000B);
    step();
    check("b2b_idle_gap", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("b2b_second_accepted", busy, 1);
    check("b2b_second_alu_a", alu_a, 16'd50);
    step(); step(); step(); step();
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_result", out_result, 64'h004C_0043_003A_0031);
    step();
    check("b2b_final_idle", in_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
